instr_fetch_unit: RTL



---
 rtl/instr_fetch_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, captures the instruction into a valid/ready output register.
// Optional FETCH_PERF_CNT_EN adds fetch/stall performance counters (fetch_cnt_o, stall_cnt_o).
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter int unsigned IMEM_WORDS = 5097
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] im_addr_o,
   input  logic [31:0] im_instr_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        valid_o,
   input  logic        ready_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic [31:0] pc4_o,
   output logic        fault_o
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] fetch_cnt_o,
   output logic [31:0] stall_cnt_o
`endif
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HALT = 2'd2;

   localparam logic [29:0] IMEM_LIMIT = 30'(IMEM_WORDS);

   logic [1:0]  state_reg, state_next;
   logic [31:0] fetch_pc_reg, fetch_pc_next;
   logic        valid_reg, valid_next;
   logic [31:0] instr_reg, instr_next;
   logic [31:0] pc_reg, pc_next;
   logic        fault_reg, fault_next;

   logic        load;
   logic        in_range;
   logic        capture;

   assign load     = !valid_reg || ready_i;
   assign in_range = (fetch_pc_reg[31:2] < IMEM_LIMIT);
   assign capture  = !redirect_i && (state_reg == ST_RUN) && load && in_range;

   always_comb begin
      state_next    = state_reg;
      fetch_pc_next = fetch_pc_reg;
      valid_next    = valid_reg;
      instr_next    = instr_reg;
      pc_next       = pc_reg;
      fault_next    = fault_reg;

      if (redirect_i) begin
         // Redirect squashes any held instruction, even one being accepted this cycle.
         fetch_pc_next = {redirect_pc_i[31:2], 2'b00};
         valid_next    = 1'b0;
         fault_next    = 1'b0;
         state_next    = ST_RUN;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               valid_next = 1'b0;
               state_next = ST_RUN;
            end
            ST_RUN: begin
               if (load) begin
                  if (in_range) begin
                     instr_next    = im_instr_i;
                     pc_next       = fetch_pc_reg;
                     valid_next    = 1'b1;
                     fetch_pc_next = fetch_pc_reg + 32'd4;
                  end else begin
                     // Fetch PC stays on the offending address for debug visibility.
                     valid_next = 1'b0;
                     fault_next = 1'b1;
                     state_next = ST_HALT;
                  end
               end
            end
            ST_HALT: begin
               valid_next = 1'b0;
            end
            default: begin
               valid_next = 1'b0;
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         fetch_pc_reg <= RESET_PC;
         valid_reg    <= 1'b0;
         instr_reg    <= 32'd0;
         pc_reg       <= 32'd0;
         fault_reg    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         fetch_pc_reg <= fetch_pc_next;
         valid_reg    <= valid_next;
         instr_reg    <= instr_next;
         pc_reg       <= pc_next;
         fault_reg    <= fault_next;
      end
   end

   assign im_addr_o = fetch_pc_reg;
   assign valid_o   = valid_reg;
   assign instr_o   = instr_reg;
   assign pc_o      = pc_reg;
   assign pc4_o     = pc_reg + 32'd4;
   assign fault_o   = fault_reg;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_reg;
   logic [31:0] stall_cnt_reg;

   // Counters observe the pipeline but are deliberately not cleared by redirect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_cnt_reg <= 32'd0;
         stall_cnt_reg <= 32'd0;
      end else begin
         if (capture)
            fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
         if (valid_reg && !ready_i)
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
   end

   assign fetch_cnt_o = fetch_cnt_reg;
   assign stall_cnt_o = stall_cnt_reg;
`endif

endmodule
